pixel_receive_interface: RTL
============================

# pixel_receive_interface

Receiving end of the pixel transfer link: accepts the toggle-strobed pixel stream (pixel, row, column, strobe) produced by the image-ROM transfer side and writes each pixel into the image-mask frame buffer. Pixels are optionally ANDed with a mask colour, checked against the expected raster order, and reported per frame. It sits between the transfer interface and the frame-buffer write port.

## Interface

- IMG_W, 320, pixels per row (columns)
- IMG_H, 240, rows per frame
- PIX_W, 12, pixel width (4:4:4 RGB)
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

- Clock  input  1  single system clock, rising edge
- Resetn  input  1  synchronous, active-low reset
- enable  input  1  1 = accept frames; 0 = return to SYNC at the next frame boundary
- pixel_in  input  PIX_W  pixel data from the transfer side
- pix_row  input  8  row of pixel_in
- pix_col  input  9  column of pixel_in
- strobe  input  1  toggles once per new pixel; both edges are valid
- mask_en  input  1  1 = apply mask_value
- mask_value  input  PIX_W  AND mask applied to pixel data
- err_clr  input  1  clears sticky error flags
- wr_en  output  1  frame-buffer write strobe, one cycle per pixel
- wr_addr  output  ADDR_W  pix_row*IMG_W + pix_col
- wr_data  output  PIX_W  masked or raw pixel
- frame_done  output  1  one-cycle pulse on the write of pixel (IMG_H-1, IMG_W-1)
- frame_count  output  8  completed frames, wraps 255->0
- busy  output  1  1 while in RECV
- err_seq  output  1  sticky: received address differs from expected raster address
- err_range  output  1  sticky: row >= IMG_H or col >= IMG_W

## Operation

- Toggle detect: strobe_q registers strobe every cycle. A cycle with strobe != strobe_q is a pixel event. strobe_q resets to 0, so strobe = 1 on the first cycle after reset counts as an event.
- Stage 1 (event cycle): capture pixel_in, pix_row, pix_col, and the range check result; assert cap_valid.
- Stage 2: compute address and masked data. Drive wr_en, wr_addr, wr_data registered.
- Masking: wr_data = mask_en ? (pixel & mask_value) : pixel. mask_en and mask_value are sampled in stage 1.
- Address arithmetic: unsigned. The product row*IMG_W is computed at ADDR_W bits. Out-of-range pixels never reach the address path.
- FSM:
  - SYNC: discard all events except (row 0, col 0) with enable = 1. That event is written, the expected address is set to (0,1), and the FSM goes to RECV.
  - RECV: every in-range event is written. If the address differs from the expected address, set err_seq, write the pixel anyway, and resync expected to received+1.
  - Expected address wraps col IMG_W-1 -> 0 with row+1, and (IMG_H-1, IMG_W-1) -> (0,0).
  - Writing (IMG_H-1, IMG_W-1) pulses frame_done and increments frame_count. It then stays in RECV if enable = 1, otherwise goes to SYNC.
- Out-of-range event: no write, err_range set, expected address unchanged, state unchanged.
- err_clr clears both sticky flags. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: the partial frame is abandoned and not counted. The next frame must start at (0,0).

## Timing

- Reset values: wr_en 0, wr_addr 0, wr_data 0, frame_done 0, frame_count 0, busy 0, err_seq 0, err_range 0, state SYNC, strobe_q 0.
- Latency: inputs present at clock edge k with a strobe toggle -> wr_en = 1 in the cycle after edge k+1 (2 cycles). frame_done is coincident with that wr_en.
- Throughput: one pixel per cycle. Strobe may toggle every cycle, and back-to-back events are all written.
- No toggle means no write. A static strobe is a stalled link.
- busy rises in the same cycle as the first wr_en of a frame.
- err flags rise with the same 2-cycle latency as wr_en.

## Test plan

- Params IMG_W=4, IMG_H=3. Toggle strobe every cycle over full raster (0,0)..(2,3) with pixel = 0x100+index -> 12 writes at addresses 0..11, data 0x100..0x10B; frame_done pulses once with addr 11; frame_count = 1; no errors.
- Stream starts at (1,2) then full frame -> first 6 events discarded (no wr_en); writes begin at addr 0; err_seq stays 0.
- Skip (0,2) in RECV (send (0,1) then (0,3)) -> both written (addr 1, 3); err_seq = 1 on the addr-3 write; next (1,0) is expected with no further error. err_clr -> err_seq 0.
- Event with row 3 (= IMG_H) -> no wr_en, err_range = 1; same cycle err_clr = 1 -> flag stays 1.
- mask_en = 1, mask_value = 0xF00, pixel 0xABC -> wr_data 0xA00; mask_en = 0 -> 0xABC.
- Reset asserted after 5 writes -> all outputs 0 next cycle; frame_count 0. Hold strobe constant for 10 cycles -> no wr_en.

Source files
------------

// File: rtl/pixel_receive_interface.sv
// pixel_receive_interface: toggle-strobed pixel receiver writing a raster-checked, optionally masked stream into the frame buffer
// Clock, Resetn          : system clock, synchronous active-low reset
// enable_i               : accept frames; when low, drop back to SYNC at the next frame boundary
// pixel_in_i, pix_row_i,
// pix_col_i, strobe_i    : pixel stream; every strobe toggle is one pixel
// mask_en_i, mask_value_i: optional AND mask on pixel data
// err_clr_i              : clears the sticky error flags
// wr_en_o, wr_addr_o,
// wr_data_o              : frame-buffer write port
// frame_done_o,
// frame_count_o, busy_o  : frame progress
// err_seq_o, err_range_o : sticky raster-order and coordinate-range errors
module pixel_receive_interface #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 17
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              enable_i,
  input  logic [PIX_W-1:0]  pixel_in_i,
  input  logic [7:0]        pix_row_i,
  input  logic [8:0]        pix_col_i,
  input  logic              strobe_i,
  input  logic              mask_en_i,
  input  logic [PIX_W-1:0]  mask_value_i,
  input  logic              err_clr_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [PIX_W-1:0]  wr_data_o,
  output logic              frame_done_o,
  output logic [7:0]        frame_count_o,
  output logic              busy_o,
  output logic              err_seq_o,
  output logic              err_range_o
);
  typedef enum logic {SYNC, RECV} state_t;
  localparam logic [7:0]        LAST_R = 8'(IMG_H - 1);
  localparam logic [8:0]        LAST_C = 9'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_SZ = ADDR_W'(IMG_W);
  state_t             state_q;
  logic               strobe_q;
  logic               cap_valid_q;
  logic               cap_oor_q;
  logic               cap_en_q;
  logic [PIX_W-1:0]   cap_pix_q;
  logic [7:0]         cap_row_q;
  logic [8:0]         cap_col_q;
  logic [7:0]         exp_row_q;
  logic [8:0]         exp_col_q;
  logic               event_d;
  logic               oor_d;
  logic               wr_d;
  logic               last_d;
  logic               mis_d;
  logic               stay_d;
  logic [7:0]         nxt_row_d;
  logic [8:0]         nxt_col_d;
  logic [ADDR_W-1:0]  addr_d;
  always_comb begin
    event_d   = strobe_i != strobe_q;
    oor_d     = int'(pix_row_i) >= IMG_H || int'(pix_col_i) >= IMG_W;
    // SYNC only lets the top-left pixel of an enabled frame through
    wr_d      = cap_valid_q && !cap_oor_q &&
                (state_q == RECV || (cap_row_q == 8'd0 && cap_col_q == 9'd0 && cap_en_q));
    mis_d     = state_q == RECV && (cap_row_q != exp_row_q || cap_col_q != exp_col_q);
    last_d    = cap_row_q == LAST_R && cap_col_q == LAST_C;
    stay_d    = !(last_d && !cap_en_q);
    // expected position always follows the received one, so a skip resyncs
    nxt_col_d = cap_col_q == LAST_C ? 9'd0 : cap_col_q + 9'd1;
    nxt_row_d = cap_col_q != LAST_C ? cap_row_q : last_d ? 8'd0 : cap_row_q + 8'd1;
    addr_d    = ADDR_W'(cap_row_q) * ROW_SZ + ADDR_W'(cap_col_q);
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q       <= SYNC;
      strobe_q      <= 1'b0;
      cap_valid_q   <= 1'b0;
      cap_oor_q     <= 1'b0;
      cap_en_q      <= 1'b0;
      cap_pix_q     <= '0;
      cap_row_q     <= '0;
      cap_col_q     <= '0;
      exp_row_q     <= '0;
      exp_col_q     <= '0;
      wr_en_o       <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      frame_done_o  <= 1'b0;
      frame_count_o <= '0;
      busy_o        <= 1'b0;
      err_seq_o     <= 1'b0;
      err_range_o   <= 1'b0;
    end else begin
      strobe_q    <= strobe_i;
      cap_valid_q <= event_d;
      if (event_d) begin
        cap_pix_q <= mask_en_i ? (pixel_in_i & mask_value_i) : pixel_in_i;
        cap_row_q <= pix_row_i;
        cap_col_q <= pix_col_i;
        cap_oor_q <= oor_d;
        cap_en_q  <= enable_i;
      end
      wr_en_o      <= wr_d;
      frame_done_o <= wr_d && last_d;
      if (wr_d) begin
        wr_addr_o <= addr_d;
        wr_data_o <= cap_pix_q;
        exp_row_q <= nxt_row_d;
        exp_col_q <= nxt_col_d;
        state_q   <= stay_d ? RECV : SYNC;
        busy_o    <= stay_d;
      end
      if (wr_d && last_d)
        frame_count_o <= frame_count_o + 8'd1;
      // a new error in the same cycle as a clear still lands
      err_seq_o   <= (wr_d && mis_d) || (err_seq_o && !err_clr_i);
      err_range_o <= (cap_valid_q && cap_oor_q) || (err_range_o && !err_clr_i);
    end
  end
endmodule
